// File: rtl/demux_pkg.sv
// demux_pkg: shared defaults and types for the stream demultiplexer
package demux_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;
  typedef logic [DEF_WIDTH-1:0] word_t;
  typedef enum logic {DEST0 = 1'b0, DEST1 = 1'b1} dest_e;
endpackage

// File: rtl/demux_fifo.sv
// demux_fifo: per-output FIFO with occupancy count, head driven straight from storage
module demux_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int LVLW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [LVLW-1:0]  level
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0] level_q, level_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d = level_q + LVLW'(push) - LVLW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  end
  assign head_data = mem_q[rd_ptr_q];
  assign empty = level_q == '0;
  assign full = level_q == LVLW'(DEPTH);
  assign level = level_q;
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
endmodule

// File: rtl/stream_demux.sv
// stream_demux: steers one valid/ready stream to two independently buffered outputs
module stream_demux
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int LVLW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [LVLW-1:0]  level0,
  output logic [LVLW-1:0]  level1
);
  dest_e dest;
  logic full0, full1, empty0, empty1, push0, push1, pop0, pop1;
  always_comb begin
    dest = dest_e'(in_sel);
    in_ready = dest == DEST1 ? !full1 : !full0;
    push0 = in_valid && in_ready && dest == DEST0;
    push1 = in_valid && in_ready && dest == DEST1;
    out0_valid = !empty0;
    out1_valid = !empty1;
    pop0 = out0_valid && out0_ready;
    pop1 = out1_valid && out1_ready;
  end
  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push(push0), .push_data(in_data), .pop(pop0),
    .head_data(out0_data), .empty(empty0), .full(full0), .level(level0)
  );
  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push(push1), .push_data(in_data), .pop(pop1),
    .head_data(out1_data), .empty(empty1), .full(full1), .level(level1)
  );
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: table-driven vectors plus scoreboarded corner-case sequences
module tb_stream_demux;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_sel = 0;
  logic [31:0] in_data = '0;
  logic out0_valid, out0_ready = 1, out1_valid, out1_ready = 1;
  logic [31:0] out0_data, out1_data;
  logic [1:0] level0, level1;
  int total = 0, passed = 0, cnt0 = 0, cnt1 = 0;
  logic [31:0] q0[$], q1[$];
  typedef struct {
    logic v, sel; logic [31:0] d; logic r0, r1;
    logic e_rdy, e_v0, e_v1; logic [1:0] e_l0, e_l1;
  } vec_t;
  vec_t vecs[12];
  always #5 clk = ~clk;
  stream_demux dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out0_valid(out0_valid),
    .out0_ready(out0_ready), .out0_data(out0_data), .out1_valid(out1_valid),
    .out1_ready(out1_ready), .out1_data(out1_data), .level0(level0), .level1(level1)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic sb_step();
    logic [31:0] e;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out0_valid && out0_ready) begin
        cnt0++;
        if (q0.size() == 0) chk("out0_spurious", out0_data, 32'hxxxxxxxx);
        else begin e = q0.pop_front(); chk("out0_data", out0_data, e); end
      end
      if (out1_valid && out1_ready) begin
        cnt1++;
        if (q1.size() == 0) chk("out1_spurious", out1_data, 32'hxxxxxxxx);
        else begin e = q1.pop_front(); chk("out1_data", out1_data, e); end
      end
      if (in_valid && in_ready) begin
        if (in_sel) q1.push_back(in_data);
        else q0.push_back(in_data);
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic s, input logic [31:0] d);
    in_valid = v;
    in_sel = s;
    in_data = d;
  endtask
  task automatic chk_reset_state();
    chk("rst_v0", 32'(out0_valid), 0);
    chk("rst_v1", 32'(out1_valid), 0);
    chk("rst_l0", 32'(level0), 0);
    chk("rst_l1", 32'(level1), 0);
    chk("rst_rdy", 32'(in_ready), 1);
  endtask
  initial begin
    int c0, c1;
    bit acc;
    vecs[0]  = '{1, 0, 32'hAAAAAAAA, 1, 1, 1, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 32'h55555555, 1, 1, 1, 1, 0, 1, 0};
    vecs[2]  = '{0, 0, 32'h0,        1, 1, 1, 0, 1, 0, 1};
    vecs[3]  = '{1, 0, 32'h12345678, 0, 1, 1, 0, 0, 0, 0};
    vecs[4]  = '{1, 0, 32'h87654321, 0, 1, 1, 1, 0, 1, 0};
    vecs[5]  = '{1, 0, 32'hDEADBEEF, 0, 1, 0, 1, 0, 2, 0};
    vecs[6]  = '{1, 1, 32'hDEADBEEF, 0, 1, 1, 1, 0, 2, 0};
    vecs[7]  = '{0, 0, 32'h0,        0, 1, 0, 1, 1, 2, 1};
    vecs[8]  = '{0, 0, 32'h0,        1, 1, 0, 1, 0, 2, 0};
    vecs[9]  = '{1, 0, 32'h00000001, 1, 1, 1, 1, 0, 1, 0};
    vecs[10] = '{0, 0, 32'h0,        1, 1, 1, 1, 0, 1, 0};
    vecs[11] = '{0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0};
    drive(1'($urandom), 1'($urandom), $urandom);
    out0_ready = 1'($urandom);
    out1_ready = 1'($urandom);
    #1 chk_reset_state();
    tick();
    tick();
    rst_n = 1;
    drive(0, 0, 0);
    out0_ready = 1;
    out1_ready = 1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].sel, vecs[i].d);
      out0_ready = vecs[i].r0;
      out1_ready = vecs[i].r1;
      @(negedge clk);
      chk($sformatf("vec%0d_rdy", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_v0", i), 32'(out0_valid), 32'(vecs[i].e_v0));
      chk($sformatf("vec%0d_v1", i), 32'(out1_valid), 32'(vecs[i].e_v1));
      chk($sformatf("vec%0d_l0", i), 32'(level0), 32'(vecs[i].e_l0));
      chk($sformatf("vec%0d_l1", i), 32'(level1), 32'(vecs[i].e_l1));
      sb_step();
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0);
    out0_ready = 0;
    out1_ready = 0;
    drive(1, 0, 32'h11111111); tick();
    drive(1, 0, 32'h22222222); tick();
    drive(1, 1, 32'h33333333); tick();
    drive(0, 0, 0);
    @(negedge clk);
    chk("pre_rst_l0", 32'(level0), 2);
    chk("pre_rst_l1", 32'(level1), 1);
    @(posedge clk);
    #3;
    rst_n = 0;
    drive(1'($urandom), 1'($urandom), $urandom);
    out0_ready = 1'($urandom);
    out1_ready = 1'($urandom);
    #1 chk_reset_state();
    tick();
    rst_n = 1;
    drive(1, 0, 32'hCAFEF00D);
    out0_ready = 1;
    out1_ready = 1;
    c0 = cnt0;
    c1 = cnt1;
    tick();
    drive(0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_out0_words", 32'(cnt0 - c0), 1);
    chk("post_rst_out1_words", 32'(cnt1 - c1), 0);
    chk("post_rst_q0_left", 32'(q0.size()), 0);
    c0 = cnt0;
    out0_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 32'(i));
      acc = 0;
      for (int t = 0; t < 20 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        sb_step();
        @(posedge clk);
        #1;
        out0_ready = ~out0_ready;
      end
      if (!acc) chk("wrap_accept_timeout", 32'(i), 32'hFFFFFFFF);
    end
    drive(0, 0, 0);
    for (int t = 0; t < 50 && q0.size() != 0; t++) begin
      tick();
      out0_ready = ~out0_ready;
    end
    chk("wrap_words", 32'(cnt0 - c0), 5);
    chk("wrap_q0_left", 32'(q0.size()), 0);
    chk("final_q1_left", 32'(q1.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
